// File: rtl/hdmi_timing_monitor.sv
// Passive HDMI timing monitor: measures h/v totals and actives, flags errors, tracks lock; CRC under HDMI_TIMING_MONITOR_CRC_EN.
// Results update 2 clocks after the vsync pin edge; read-only tap, never stalls or drives the video path.
module hdmi_timing_monitor #(
  parameter int CNT_W       = 13,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             data_e,
  input  logic [23:0]      data,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic [15:0]      frame_crc,
  output logic             frame_done,
  output logic             locked,
  output logic             err_ovf,
  output logic             err_de
);
  typedef enum logic [1:0] {IDLE, SYNC, MEASURE} state_t;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [3:0]       LF   = 4'(LOCK_FRAMES);

  state_t             r_state;
  logic               r_hs, r_vs, r_de, r_hs_d, r_vs_d, r_de_d;
  logic [CNT_W-1:0]   r_hcnt, r_htot, r_decnt, r_href, r_vcnt, r_vact;
  logic               r_ref_vld, r_de_skip, r_err_ovf, r_err_de;
  logic [3:0]         r_lock_cnt;
  logic               r_prev_vld;
  logic [4*CNT_W-1:0] r_prev_tuple;

  logic               w_hs_edge, w_vs_edge, w_de_fall, w_run, w_hcnt_max, w_match;
  logic [CNT_W-1:0]   w_htot_nxt;
  logic [4*CNT_W-1:0] w_tuple;

  // Sync polarity is normalised here so everything downstream sees active-high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_de   <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
    end else begin
      r_hs   <= (hsync == SYNC_POL);
      r_vs   <= (vsync == SYNC_POL);
      r_de   <= data_e;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_de_d <= r_de;
    end
  end

  assign w_hs_edge  = r_hs & ~r_hs_d;
  assign w_vs_edge  = r_vs & ~r_vs_d;
  assign w_de_fall  = r_de_d & ~r_de;
  assign w_run      = enable && (r_state != IDLE);
  assign w_hcnt_max = (r_hcnt == CMAX);
  // A line closing in the vsync cycle still belongs to the frame being latched.
  assign w_htot_nxt = w_hs_edge ? (w_hcnt_max ? CMAX : r_hcnt + 1'b1) : r_htot;
  assign w_tuple    = {w_htot_nxt, r_href, r_vcnt, r_vact};
  assign w_match    = r_prev_vld && (w_tuple == r_prev_tuple) && !r_err_ovf && !r_err_de;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hcnt    <= '0;
      r_htot    <= '0;
      r_decnt   <= '0;
      r_href    <= '0;
      r_vcnt    <= '0;
      r_vact    <= '0;
      r_ref_vld <= 1'b0;
      r_de_skip <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_de  <= 1'b0;
    end else if (!w_run) begin
      r_hcnt    <= '0;
      r_htot    <= '0;
      r_decnt   <= '0;
      r_href    <= '0;
      r_vcnt    <= '0;
      r_vact    <= '0;
      r_ref_vld <= 1'b0;
      r_de_skip <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_de  <= 1'b0;
    end else begin
      if (w_hs_edge)        r_hcnt <= '0;
      else if (!w_hcnt_max) r_hcnt <= r_hcnt + 1'b1;
      r_htot <= w_htot_nxt;
      if (r_de) r_decnt <= !r_de_d ? CNT_W'(1) : ((r_decnt == CMAX) ? CMAX : r_decnt + 1'b1);
      if (w_vs_edge) begin
        // hsync coincident with vsync opens the new frame's line count.
        r_vcnt    <= {{(CNT_W-1){1'b0}}, w_hs_edge};
        r_vact    <= '0;
        r_href    <= '0;
        r_ref_vld <= 1'b0;
        r_de_skip <= r_de;
        r_err_ovf <= 1'b0;
        r_err_de  <= 1'b0;
      end else begin
        if (w_hs_edge) begin
          if (r_vcnt == CMAX) r_err_ovf <= 1'b1;
          else                r_vcnt    <= r_vcnt + 1'b1;
        end
        if (w_de_fall) begin
          if (r_de_skip) begin
            r_de_skip <= 1'b0;
          end else begin
            if (r_vact == CMAX) r_err_ovf <= 1'b1;
            else                r_vact    <= r_vact + 1'b1;
            if (!r_ref_vld) begin
              r_href    <= r_decnt;
              r_ref_vld <= 1'b1;
            end else if (r_decnt != r_href) begin
              r_err_de <= 1'b1;
            end
          end
        end
        if (!w_hs_edge && w_hcnt_max)                 r_err_ovf <= 1'b1;
        if (r_de && r_de_d && (r_decnt == CMAX))      r_err_ovf <= 1'b1;
      end
    end
  end

`ifdef HDMI_TIMING_MONITOR_CRC_EN
  logic [23:0] r_data;
  logic [15:0] r_crc;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 23; i >= 0; i--) x = {x[14:0], 1'b0} ^ ((x[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return x;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data <= '0;
      r_crc  <= 16'hFFFF;
    end else begin
      r_data <= data;
      if (!w_run || w_vs_edge) r_crc <= 16'hFFFF;
      else if (r_de)           r_crc <= crc16_step(r_crc, r_data);
    end
  end
`else
  logic w_unused_data;
  assign w_unused_data = ^data;
  assign frame_crc     = 16'h0000;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      h_total      <= '0;
      h_active     <= '0;
      v_total      <= '0;
      v_active     <= '0;
      frame_done   <= 1'b0;
      locked       <= 1'b0;
      err_ovf      <= 1'b0;
      err_de       <= 1'b0;
      r_lock_cnt   <= '0;
      r_prev_vld   <= 1'b0;
      r_prev_tuple <= '0;
`ifdef HDMI_TIMING_MONITOR_CRC_EN
      frame_crc    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        r_state    <= IDLE;
        locked     <= 1'b0;
        r_lock_cnt <= '0;
        r_prev_vld <= 1'b0;
      end else begin
        case (r_state)
          IDLE:    r_state <= SYNC;
          SYNC:    if (w_vs_edge) r_state <= MEASURE;
          MEASURE: if (w_vs_edge) begin
            h_total      <= w_htot_nxt;
            h_active     <= r_href;
            v_total      <= r_vcnt;
            v_active     <= r_vact;
            err_ovf      <= r_err_ovf;
            err_de       <= r_err_de;
            frame_done   <= 1'b1;
`ifdef HDMI_TIMING_MONITOR_CRC_EN
            frame_crc    <= r_crc;
`endif
            r_prev_tuple <= w_tuple;
            r_prev_vld   <= 1'b1;
            if (w_match) begin
              if (r_lock_cnt != LF) r_lock_cnt <= r_lock_cnt + 1'b1;
              locked <= (r_lock_cnt >= LF - 4'd1);
            end else begin
              r_lock_cnt <= '0;
              locked     <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule
